// File: rtl/comp_frame_trailer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comp_frame_trailer_pkg                                    |
// | Brief    : Shared constants, trailer fields, FSM states and the      |
// |            trailer packing helper for the frame trailer stage.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package comp_frame_trailer_pkg;

  localparam int          AXI_DATA_BITS  = 512;
  localparam logic [31:0] FRAME_MAGIC    = 32'h475A_4631;
  localparam int          TRAILER_BYTES  = 64;

  // Byte offsets of the trailer fields inside the 64-byte beat.
  localparam int TRL_MAGIC_OFS = 0;
  localparam int TRL_LEN_OFS   = 4;
  localparam int TRL_IDX_OFS   = 8;
  localparam int TRL_FLAGS_OFS = 12;

  // Bit positions inside the flags byte.
  localparam int TRL_FLAG_SAT   = 0;
  localparam int TRL_FLAG_EMPTY = 1;

  typedef struct packed {
    logic [31:0] magic;
    logic [31:0] len;
    logic [31:0] idx;
    logic [7:0]  flags;
  } trailer_t;

  typedef enum logic [0:0] {
    ST_PASS    = 1'b0,
    ST_TRAILER = 1'b1
  } state_t;

  // Place the trailer fields at their little-endian byte offsets; all
  // remaining bytes stay zero.
  function automatic logic [TRAILER_BYTES*8-1:0] pack_trailer(input trailer_t t);
    logic [TRAILER_BYTES*8-1:0] beat;
    beat = '0;
    beat[TRL_MAGIC_OFS*8 +: 32] = t.magic;
    beat[TRL_LEN_OFS*8   +: 32] = t.len;
    beat[TRL_IDX_OFS*8   +: 32] = t.idx;
    beat[TRL_FLAGS_OFS*8 +: 8]  = t.flags;
    return beat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comp_frame_trailer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comp_frame_trailer_if                                     |
// | Brief    : AXI4-Stream bundle (tdata/tkeep/tlast/tvalid/tready) with |
// |            master (m) and slave (s) views.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface comp_frame_trailer_if
  import comp_frame_trailer_pkg::*;
#(
  parameter int DATA_BITS = AXI_DATA_BITS
);
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport m (output tdata, output tkeep, output tlast, output tvalid, input  tready);
  modport s (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/comp_frame_trailer_keep_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comp_frame_trailer_keep_popcount                          |
// | Brief    : Combinational count of set bits in a 64-bit tkeep.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module comp_frame_trailer_keep_popcount (
  input  logic [63:0] keep,
  output logic [6:0]  count
);

  // Sum every lane enable; holes in tkeep are counted as they are.
  always_comb begin
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + {6'd0, keep[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/comp_frame_trailer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comp_frame_trailer                                        |
// | Brief    : Forwards compressed beats with tlast stripped and appends |
// |            one 64-byte trailer beat (magic, length, index, flags)    |
// |            carrying tlast after every frame.                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module comp_frame_trailer
  import comp_frame_trailer_pkg::*;
#(
  parameter int          DATA_BITS = AXI_DATA_BITS,
  parameter logic [31:0] MAGIC     = FRAME_MAGIC
) (
  input  logic            clk,
  input  logic            rst_n,
  comp_frame_trailer_if.s axis_input,
  comp_frame_trailer_if.m axis_output,
  output logic [31:0]     frame_count
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  state_t      r_state;
  logic [31:0] r_byte_cnt;
  logic        r_sat;
  logic [31:0] r_frame_idx;
  logic [31:0] r_frame_count;

  logic        w_slot_free;
  logic        w_accept;
  logic [6:0]  w_beat_bytes;
  logic [32:0] w_sum;
  logic        w_overflow;
  logic [31:0] w_next_cnt;
  trailer_t    w_trailer;

  // The output register can take a new beat when empty or draining now.
  assign w_slot_free       = !axis_output.tvalid || axis_output.tready;
  assign axis_input.tready = rst_n && (r_state == ST_PASS) && w_slot_free;
  assign w_accept          = axis_input.tvalid && axis_input.tready;

  comp_frame_trailer_keep_popcount u_keep_popcount (
    .keep  (axis_input.tkeep),
    .count (w_beat_bytes)
  );

  // Saturating byte count: a carry out pins the count at all ones.
  assign w_sum      = {1'b0, r_byte_cnt} + {26'd0, w_beat_bytes};
  assign w_overflow = w_sum[32];
  assign w_next_cnt = w_overflow ? 32'hFFFF_FFFF : w_sum[31:0];

  assign frame_count = r_frame_count;

  // Assemble the trailer fields from the running frame statistics.
  always_comb begin
    w_trailer                       = '0;
    w_trailer.magic                 = MAGIC;
    w_trailer.len                   = r_byte_cnt;
    w_trailer.idx                   = r_frame_idx;
    w_trailer.flags[TRL_FLAG_SAT]   = r_sat;
    w_trailer.flags[TRL_FLAG_EMPTY] = (r_byte_cnt == 32'd0);
  end

  // Frame FSM, counters and the single output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= ST_PASS;
      r_byte_cnt         <= '0;
      r_sat              <= 1'b0;
      r_frame_idx        <= '0;
      r_frame_count      <= '0;
      axis_output.tvalid <= 1'b0;
      axis_output.tlast  <= 1'b0;
      axis_output.tkeep  <= '0;
      axis_output.tdata  <= '0;
    end else begin
      case (r_state)
        ST_PASS: begin
          if (w_accept) begin
            axis_output.tdata  <= axis_input.tdata;
            axis_output.tkeep  <= axis_input.tkeep;
            axis_output.tlast  <= 1'b0;
            axis_output.tvalid <= 1'b1;
            r_byte_cnt         <= w_next_cnt;
            if (w_overflow) begin
              r_sat <= 1'b1;
            end
            if (axis_input.tlast) begin
              r_state <= ST_TRAILER;
            end
          end else if (w_slot_free) begin
            axis_output.tvalid <= 1'b0;
          end
        end
        ST_TRAILER: begin
          if (w_slot_free) begin
            axis_output.tdata  <= pack_trailer(w_trailer);
            axis_output.tkeep  <= {KEEP_BITS{1'b1}};
            axis_output.tlast  <= 1'b1;
            axis_output.tvalid <= 1'b1;
            r_byte_cnt         <= '0;
            r_sat              <= 1'b0;
            r_frame_idx        <= r_frame_idx + 32'd1;
            r_frame_count      <= r_frame_count + 32'd1;
            r_state            <= ST_PASS;
          end
        end
        default: r_state <= ST_PASS;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comp_frame_trailer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_comp_frame_trailer                                     |
// | Brief    : Self-checking bench for comp_frame_trailer with a         |
// |            transaction-level frame model and scoreboard.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_comp_frame_trailer;

  localparam logic [31:0] TB_MAGIC = 32'h475A_4631;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] frame_count;

  comp_frame_trailer_if #(.DATA_BITS(512)) in_if ();
  comp_frame_trailer_if #(.DATA_BITS(512)) out_if ();

  comp_frame_trailer #(.DATA_BITS(512)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axis_input  (in_if),
    .axis_output (out_if),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  beat_t           src_q[$];
  beat_t           exp_q[$];
  longint unsigned m_len = 0;
  logic [31:0]     m_idx = 0;
  int              trl_popped = 0;
  int              valid_pct = 100;
  int              ready_pct = 100;
  int              cyc = 0;
  int              accepted = 0;
  int              ready_low = 0;
  int              acc_cyc = 0;
  int              data_cyc = 0;
  int              trl_cyc = 0;
  logic            hold_pending = 1'b0;
  beat_t           held;
  logic [511:0]    last_trl = '0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic beat_t mk(input logic [511:0] d, input logic [63:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    return b;
  endfunction

  // Reference model: every accepted beat comes out with tlast cleared; a
  // frame end appends the trailer computed from the frame's byte total.
  task automatic model_accept(input beat_t b);
    beat_t t;
    exp_q.push_back(mk(b.data, b.keep, 1'b0));
    m_len += $countones(b.keep);
    if (b.last) begin
      t.data          = '0;
      t.data[31:0]    = TB_MAGIC;
      t.data[63:32]   = (m_len > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_len[31:0];
      t.data[95:64]   = m_idx;
      t.data[96]      = (m_len > 64'hFFFF_FFFF);
      t.data[97]      = (m_len == 0);
      t.keep          = '1;
      t.last          = 1'b1;
      exp_q.push_back(t);
      m_idx++;
      m_len = 0;
    end
  endtask

  task automatic cycle();
    beat_t e;
    logic  took;
    @(negedge clk);
    cyc++;
    if (hold_pending) begin
      check("hold_valid", out_if.tvalid, 1'b1);
      check("hold_data", out_if.tdata, held.data);
      check("hold_keep", out_if.tkeep, held.keep);
      check("hold_last", out_if.tlast, held.last);
    end
    if (rst_n && out_if.tvalid && out_if.tlast)
      check("frame_count_at_load", frame_count, trl_popped + 1);
    if (out_if.tvalid && out_if.tready) begin
      check("beat_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", out_if.tdata, e.data);
        check("out_keep", out_if.tkeep, e.keep);
        check("out_last", out_if.tlast, e.last);
        if (out_if.tlast) begin
          trl_popped++;
          trl_cyc  = cyc;
          last_trl = out_if.tdata;
        end else begin
          data_cyc = cyc;
        end
      end
    end
    hold_pending = rst_n && out_if.tvalid && !out_if.tready;
    held = mk(out_if.tdata, out_if.tkeep, out_if.tlast);
    if (rst_n && !in_if.tready) ready_low++;
    took = in_if.tvalid && in_if.tready;
    if (took) begin
      model_accept(src_q.pop_front());
      accepted++;
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (!(in_if.tvalid && !took)) begin
      if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        in_if.tvalid = 1'b1;
        in_if.tdata  = src_q[0].data;
        in_if.tkeep  = src_q[0].keep;
        in_if.tlast  = src_q[0].last;
      end else begin
        in_if.tvalid = 1'b0;
      end
    end
    out_if.tready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic run_drain(input int max_cycles);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || in_if.tvalid) && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_pending", src_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    in_if.tvalid = 1'b0;
    src_q.delete();
    cycle();
    exp_q.delete();
    m_len        = 0;
    m_idx        = 0;
    trl_popped   = 0;
    hold_pending = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic check_trl(input string tag, input logic [31:0] len,
                           input logic [31:0] idx, input logic [7:0] flags);
    check({tag, "_magic"}, last_trl[31:0], TB_MAGIC);
    check({tag, "_len"}, last_trl[63:32], len);
    check({tag, "_idx"}, last_trl[95:64], idx);
    check({tag, "_flags"}, last_trl[103:96], flags);
    check({tag, "_pad"}, last_trl[511:104], '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int a0;
    int n;
    int nb;
    int mode;
    logic [63:0] k;

    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", out_if.tvalid, 1'b0);
    check("rst_tlast", out_if.tlast, 1'b0);
    check("rst_tkeep", out_if.tkeep, '0);
    check("rst_tdata", out_if.tdata, '0);
    check("rst_frame_count", frame_count, 0);
    check("rst_in_tready", in_if.tready, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single full beat with tlast.
    ready_low = 0;
    src_q.push_back(mk(rand_data(), '1, 1'b1));
    run_drain(50);
    repeat (3) cycle();
    check("single_ready_low_cycles", ready_low, 1);
    check("single_data_latency", data_cyc - acc_cyc, 1);
    check("single_trailer_latency", trl_cyc - acc_cyc, 2);
    check("single_frame_count", frame_count, 1);
    check_trl("single_trl", 32'd64, 32'd0, 8'h00);

    // Frame with holes and an all-zero keep beat.
    src_q.push_back(mk(rand_data(), 64'h0000_0000_0000_FFFF, 1'b0));
    src_q.push_back(mk(rand_data(), 64'h0, 1'b0));
    src_q.push_back(mk(rand_data(), 64'hF0F0_0000_0000_0001, 1'b1));
    run_drain(50);
    check_trl("holey_trl", 32'd25, 32'd1, 8'h00);

    // Empty frame.
    src_q.push_back(mk(rand_data(), 64'h0, 1'b1));
    run_drain(50);
    check_trl("empty_trl", 32'd0, 32'd2, 8'h02);
    check("empty_frame_count", frame_count, 3);

    // Random backpressure over 20 frames from a fresh index.
    do_reset();
    valid_pct = 70;
    ready_pct = 30;
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        mode = $urandom_range(0, 3);
        k = (mode == 0) ? 64'h0 : (mode == 1) ? '1 : {$urandom, $urandom};
        src_q.push_back(mk(rand_data(), k, (b == nb - 1)));
      end
    end
    run_drain(5000);
    check("bp_frame_count", frame_count, 20);
    check("bp_last_idx", last_trl[95:64], 32'd19);
    valid_pct = 100;
    ready_pct = 100;
    repeat (2) cycle();

    // Saturation from a preloaded byte count.
    force dut.r_byte_cnt = 32'hFFFF_FFC0;
    @(posedge clk);
    #1;
    release dut.r_byte_cnt;
    m_len = 64'hFFFF_FFC0;
    src_q.push_back(mk(rand_data(), '1, 1'b0));
    src_q.push_back(mk(rand_data(), '1, 1'b1));
    run_drain(50);
    check_trl("sat_trl", 32'hFFFF_FFFF, 32'd20, 8'h01);
    src_q.push_back(mk(rand_data(), '1, 1'b1));
    run_drain(50);
    check_trl("post_sat_trl", 32'd64, 32'd21, 8'h00);

    // Reset after 2 of 4 beats: the partial frame is dropped.
    do_reset();
    for (int b = 0; b < 4; b++) src_q.push_back(mk(rand_data(), '1, (b == 3)));
    a0 = accepted;
    n  = 0;
    while (accepted - a0 < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("midrst_two_accepted", accepted - a0, 2);
    do_reset();
    repeat (5) cycle();
    check("midrst_frame_count", frame_count, 0);
    check("midrst_no_trailer", trl_popped, 0);
    src_q.push_back(mk(rand_data(), '1, 1'b1));
    run_drain(50);
    check_trl("midrst_next_trl", 32'd64, 32'd0, 8'h00);
    check("midrst_next_frame_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
